// File: rtl/axis_differentiator_pkg.sv
// Shared types and helpers for the differentiator sequencer and its output slice.
package axis_differentiator_pkg;

  typedef enum logic [1:0] {
    BYPASS = 2'd0,
    FILL   = 2'd1,
    RUN    = 2'd2
  } diff_state_t;

  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// One-stage registered AXIS slice; optionally replaces the accepted beat's data with zero.
module axis_reg_slice #(
  parameter int AXIS_TDATA_WIDTH = 32
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        zero_data,
  input  logic                        s_tvalid,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_tdata,
  output logic                        s_tready,
  output logic                        m_tvalid,
  output logic [AXIS_TDATA_WIDTH-1:0] m_tdata,
  input  logic                        m_tready
);

  logic                        vld_q, vld_d;
  logic [AXIS_TDATA_WIDTH-1:0] dat_q, dat_d;
  logic                        accept;

  // Ready is held low during reset so no beat is taken from an unsettled slice.
  assign s_tready = aresetn & (~vld_q | m_tready);
  assign accept   = s_tvalid & s_tready;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (accept) begin
      vld_d = 1'b1;
      dat_d = zero_data ? '0 : s_tdata;
    end else if (m_tready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign m_tvalid = vld_q;
  assign m_tdata  = dat_q;

endmodule

// File: rtl/axis_differentiator_ctrl.sv
// Sequencer for the streaming differentiator: owns its enable and zeroes the
// output stream until the differentiator history holds only post-enable samples.
module axis_differentiator_ctrl
  import axis_differentiator_pkg::*;
#(
  parameter  int AXIS_TDATA_WIDTH = 32,
  parameter  int WARMUP_SAMPLES   = 7,
  localparam int CNT_W            = cnt_width(WARMUP_SAMPLES)
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        enable_req,
  input  logic                        restart,
  output logic                        diff_enable,
  input  logic                        S_AXIS_tvalid,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
  output logic                        S_AXIS_tready,
  output logic                        M_AXIS_tvalid,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
  input  logic                        M_AXIS_tready,
  output logic [1:0]                  state,
  output logic [CNT_W-1:0]            warmup_cnt
);

  localparam logic [CNT_W-1:0] LAST_CNT =
    CNT_W'((WARMUP_SAMPLES > 0) ? WARMUP_SAMPLES - 1 : 0);

  diff_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             diff_en_q;
  logic             accept;

  assign accept = S_AXIS_tvalid & S_AXIS_tready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!enable_req) begin
      state_d = BYPASS;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        BYPASS: begin
          state_d = (WARMUP_SAMPLES == 0) ? RUN : FILL;
          cnt_d   = '0;
        end
        RUN: begin
          if (restart) begin
            state_d = (WARMUP_SAMPLES == 0) ? RUN : FILL;
            cnt_d   = '0;
          end
        end
        FILL: begin
          // A restart wins over a same-cycle accept: that beat is zeroed but not counted.
          if (restart) begin
            cnt_d = '0;
          end else if (accept) begin
            if (cnt_q == LAST_CNT) begin
              state_d = RUN;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_d = BYPASS;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // diff_enable comes straight from a flop so the datapath never sees a decode glitch.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= BYPASS;
      cnt_q     <= '0;
      diff_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      diff_en_q <= (state_d != BYPASS);
    end
  end

  assign diff_enable = diff_en_q;
  assign state       = state_q;
  assign warmup_cnt  = cnt_q;

  axis_reg_slice #(
    .AXIS_TDATA_WIDTH(AXIS_TDATA_WIDTH)
  ) u_slice (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .zero_data(state_q == FILL),
    .s_tvalid (S_AXIS_tvalid),
    .s_tdata  (S_AXIS_tdata),
    .s_tready (S_AXIS_tready),
    .m_tvalid (M_AXIS_tvalid),
    .m_tdata  (M_AXIS_tdata),
    .m_tready (M_AXIS_tready)
  );

endmodule

// File: tb/tb_axis_differentiator_ctrl.sv
// Directed bench for axis_differentiator_ctrl (WARMUP_SAMPLES = 7 and = 0 builds).
module tb_axis_differentiator_ctrl;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        enable_req = 1'b0, restart = 1'b0;
  logic        s_tvalid = 1'b0, m_tready = 1'b1;
  logic [31:0] s_tdata = '0;
  logic        diff_enable, S_AXIS_tready, M_AXIS_tvalid;
  logic [31:0] M_AXIS_tdata;
  logic [1:0]  state;
  logic [2:0]  warmup_cnt;

  logic        en0 = 1'b0, rs0 = 1'b0, s_tvalid0 = 1'b0, m_tready0 = 1'b1;
  logic [31:0] s_tdata0 = '0;
  logic        diff_enable0, S_AXIS_tready0, M_AXIS_tvalid0;
  logic [31:0] M_AXIS_tdata0;
  logic [1:0]  state0;
  logic [0:0]  warmup_cnt0;

  int checks = 0, failures = 0;
  logic [31:0] out_q[$];

  always #5 aclk = ~aclk;

  axis_differentiator_ctrl #(.AXIS_TDATA_WIDTH(32), .WARMUP_SAMPLES(7)) dut (
    .aclk(aclk), .aresetn(aresetn), .enable_req(enable_req), .restart(restart),
    .diff_enable(diff_enable), .S_AXIS_tvalid(s_tvalid), .S_AXIS_tdata(s_tdata),
    .S_AXIS_tready(S_AXIS_tready), .M_AXIS_tvalid(M_AXIS_tvalid),
    .M_AXIS_tdata(M_AXIS_tdata), .M_AXIS_tready(m_tready), .state(state),
    .warmup_cnt(warmup_cnt));

  axis_differentiator_ctrl #(.AXIS_TDATA_WIDTH(32), .WARMUP_SAMPLES(0)) dut0 (
    .aclk(aclk), .aresetn(aresetn), .enable_req(en0), .restart(rs0),
    .diff_enable(diff_enable0), .S_AXIS_tvalid(s_tvalid0), .S_AXIS_tdata(s_tdata0),
    .S_AXIS_tready(S_AXIS_tready0), .M_AXIS_tvalid(M_AXIS_tvalid0),
    .M_AXIS_tdata(M_AXIS_tdata0), .M_AXIS_tready(m_tready0), .state(state0),
    .warmup_cnt(warmup_cnt0));

  // Collects every beat delivered downstream by the main instance.
  always @(posedge aclk)
    if (aresetn && M_AXIS_tvalid && m_tready) out_q.push_back(M_AXIS_tdata);

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic send(input int start, input int n);
    for (int i = 0; i < n; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = 32'(start + i);
      step();
    end
    s_tvalid = 1'b0;
  endtask

  task automatic flush();
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    step();
    step();
  endtask

  task automatic test_reset();
    step();
    step();
    checks++; if (state !== 2'd0 || diff_enable !== 1'b0 || warmup_cnt !== 3'd0) begin
      failures++; $display("FAIL reset_idle state=%0d diff=%0b cnt=%0d expected 0/0/0", state, diff_enable, warmup_cnt); end
    checks++; if (M_AXIS_tvalid !== 1'b0 || M_AXIS_tdata !== 32'd0 || S_AXIS_tready !== 1'b0) begin
      failures++; $display("FAIL reset_axis mvld=%0b mdata=%0h srdy=%0b expected 0/0/0", M_AXIS_tvalid, M_AXIS_tdata, S_AXIS_tready); end
    aresetn = 1'b1;
    step();
    enable_req = 1'b1; m_tready = 1'b0; s_tvalid = 1'b1; s_tdata = 32'd55;
    step();
    s_tvalid = 1'b0;
    checks++; if (M_AXIS_tvalid !== 1'b1 || M_AXIS_tdata !== 32'd55 || state !== 2'd1 || diff_enable !== 1'b1) begin
      failures++; $display("FAIL pre_reset mvld=%0b mdata=%0d state=%0d diff=%0b expected 1/55/1/1", M_AXIS_tvalid, M_AXIS_tdata, state, diff_enable); end
    #2 aresetn = 1'b0;
    #1;
    checks++; if (M_AXIS_tvalid !== 1'b0 || M_AXIS_tdata !== 32'd0 || state !== 2'd0 || diff_enable !== 1'b0 || S_AXIS_tready !== 1'b0) begin
      failures++; $display("FAIL async_reset mvld=%0b mdata=%0h state=%0d diff=%0b srdy=%0b expected all 0", M_AXIS_tvalid, M_AXIS_tdata, state, diff_enable, S_AXIS_tready); end
    enable_req = 1'b0; m_tready = 1'b1;
    step();
    aresetn = 1'b1;
    step();
  endtask

  task automatic test_bypass();
    for (int i = 1; i <= 3; i++) begin
      s_tvalid = 1'b1; s_tdata = 32'(i);
      step();
      checks++; if (M_AXIS_tvalid !== 1'b1 || M_AXIS_tdata !== 32'(i) || diff_enable !== 1'b0) begin
        failures++; $display("FAIL bypass_beat%0d mvld=%0b mdata=%0d diff=%0b expected 1/%0d/0", i, M_AXIS_tvalid, M_AXIS_tdata, diff_enable, i); end
    end
    s_tvalid = 1'b0; restart = 1'b1;
    step();
    restart = 1'b0;
    checks++; if (state !== 2'd0 || M_AXIS_tvalid !== 1'b0) begin
      failures++; $display("FAIL bypass_restart state=%0d mvld=%0b expected 0/0", state, M_AXIS_tvalid); end
  endtask

  task automatic test_enable_fill();
    logic [31:0] exp[$];
    out_q.delete();
    enable_req = 1'b1;
    step();
    checks++; if (diff_enable !== 1'b1 || state !== 2'd1) begin
      failures++; $display("FAIL enable_fill diff=%0b state=%0d expected 1/1", diff_enable, state); end
    for (int k = 0; k <= 10; k++) begin
      s_tvalid = 1'b1; s_tdata = 32'(10 + k);
      step();
      if (k == 5) begin
        checks++; if (state !== 2'd1 || warmup_cnt !== 3'd6) begin
          failures++; $display("FAIL fill_6th state=%0d cnt=%0d expected 1/6", state, warmup_cnt); end
      end
      if (k == 6) begin
        checks++; if (state !== 2'd2 || warmup_cnt !== 3'd0) begin
          failures++; $display("FAIL fill_7th state=%0d cnt=%0d expected 2/0", state, warmup_cnt); end
      end
    end
    flush();
    exp = '{0, 0, 0, 0, 0, 0, 0, 17, 18, 19, 20};
    checks++; if (out_q.size() != exp.size()) begin
      failures++; $display("FAIL enable_count got %0d beats expected %0d", out_q.size(), exp.size()); end
    else for (int i = 0; i < exp.size(); i++) begin
      checks++; if (out_q[i] !== exp[i]) begin
        failures++; $display("FAIL enable_beat%0d got %0d expected %0d", i, out_q[i], exp[i]); end
    end
  endtask

  task automatic test_fill_stall();
    logic [31:0] exp[$];
    logic [31:0] held;
    logic        acc;
    int sent = 0, c = 0;
    enable_req = 1'b0; step();
    enable_req = 1'b1; step();
    out_q.delete();
    held = '0;
    while (sent < 10 && c < 100) begin
      s_tvalid = (c % 2 == 0);
      s_tdata  = 32'(100 + sent);
      m_tready = !(c >= 3 && c <= 5);
      #1;
      if (c == 3) held = M_AXIS_tdata;
      if (c == 4 || c == 5) begin
        checks++; if (M_AXIS_tvalid !== 1'b1 || M_AXIS_tdata !== held) begin
          failures++; $display("FAIL stall_hold c=%0d mvld=%0b mdata=%0h expected 1/%0h", c, M_AXIS_tvalid, M_AXIS_tdata, held); end
      end
      acc = s_tvalid && S_AXIS_tready;
      step();
      if (acc) sent++;
      c++;
    end
    checks++; if (sent != 10) begin
      failures++; $display("FAIL stall_timeout sent=%0d expected 10", sent); end
    flush();
    exp = '{0, 0, 0, 0, 0, 0, 0, 107, 108, 109};
    checks++; if (out_q.size() != exp.size() || state !== 2'd2) begin
      failures++; $display("FAIL stall_count got %0d beats state=%0d expected %0d/2", out_q.size(), state, exp.size()); end
    else for (int i = 0; i < exp.size(); i++) begin
      checks++; if (out_q[i] !== exp[i]) begin
        failures++; $display("FAIL stall_beat%0d got %0d expected %0d", i, out_q[i], exp[i]); end
    end
  endtask

  task automatic test_restart();
    logic [31:0] exp[$];
    out_q.delete();
    restart = 1'b1;
    step();
    restart = 1'b0;
    checks++; if (state !== 2'd1 || warmup_cnt !== 3'd0 || diff_enable !== 1'b1) begin
      failures++; $display("FAIL restart_run state=%0d cnt=%0d diff=%0b expected 1/0/1", state, warmup_cnt, diff_enable); end
    send(200, 4);
    checks++; if (warmup_cnt !== 3'd4) begin
      failures++; $display("FAIL restart_cnt4 got %0d expected 4", warmup_cnt); end
    s_tvalid = 1'b1; s_tdata = 32'd204; restart = 1'b1;
    step();
    restart = 1'b0; s_tvalid = 1'b0;
    checks++; if (state !== 2'd1 || warmup_cnt !== 3'd0) begin
      failures++; $display("FAIL restart_fill state=%0d cnt=%0d expected 1/0", state, warmup_cnt); end
    send(205, 7);
    checks++; if (state !== 2'd2) begin
      failures++; $display("FAIL restart_done state=%0d expected 2", state); end
    send(212, 2);
    flush();
    exp = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 212, 213};
    checks++; if (out_q.size() != exp.size()) begin
      failures++; $display("FAIL restart_count got %0d beats expected %0d", out_q.size(), exp.size()); end
    else for (int i = 0; i < exp.size(); i++) begin
      checks++; if (out_q[i] !== exp[i]) begin
        failures++; $display("FAIL restart_beat%0d got %0d expected %0d", i, out_q[i], exp[i]); end
    end
  endtask

  task automatic test_disable_and_zero_warmup();
    logic [31:0] exp[$];
    enable_req = 1'b0; step();
    enable_req = 1'b1; step();
    out_q.delete();
    send(300, 3);
    checks++; if (warmup_cnt !== 3'd3 || state !== 2'd1) begin
      failures++; $display("FAIL disable_pre cnt=%0d state=%0d expected 3/1", warmup_cnt, state); end
    enable_req = 1'b0;
    step();
    checks++; if (state !== 2'd0 || diff_enable !== 1'b0 || warmup_cnt !== 3'd0) begin
      failures++; $display("FAIL disable_bypass state=%0d diff=%0b cnt=%0d expected 0/0/0", state, diff_enable, warmup_cnt); end
    send(310, 2);
    flush();
    exp = '{0, 0, 0, 310, 311};
    checks++; if (out_q.size() != exp.size()) begin
      failures++; $display("FAIL disable_count got %0d beats expected %0d", out_q.size(), exp.size()); end
    else for (int i = 0; i < exp.size(); i++) begin
      checks++; if (out_q[i] !== exp[i]) begin
        failures++; $display("FAIL disable_beat%0d got %0d expected %0d", i, out_q[i], exp[i]); end
    end
    en0 = 1'b1;
    step();
    checks++; if (state0 !== 2'd2 || diff_enable0 !== 1'b1) begin
      failures++; $display("FAIL w0_enable state=%0d diff=%0b expected 2/1", state0, diff_enable0); end
    s_tvalid0 = 1'b1; s_tdata0 = 32'd400;
    step();
    checks++; if (M_AXIS_tvalid0 !== 1'b1 || M_AXIS_tdata0 !== 32'd400) begin
      failures++; $display("FAIL w0_beat0 mvld=%0b mdata=%0d expected 1/400", M_AXIS_tvalid0, M_AXIS_tdata0); end
    s_tdata0 = 32'd401; rs0 = 1'b1;
    step();
    rs0 = 1'b0; s_tvalid0 = 1'b0;
    checks++; if (M_AXIS_tdata0 !== 32'd401 || state0 !== 2'd2) begin
      failures++; $display("FAIL w0_restart mdata=%0d state=%0d expected 401/2", M_AXIS_tdata0, state0); end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_enable_fill();
    test_fill_stall();
    test_restart();
    test_disable_and_zero_warmup();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axis_differentiator_ctrl.md
Name: axis_differentiator_ctrl

Overview:
Sequencer for the streaming differentiator datapath. It owns the datapath's `enable` input and switches it only on the controller's own state transitions. After each enable or restart it holds the output stream at zero until the differentiator's history registers contain only post-enable samples. It sits directly after the differentiator and in front of the downstream consumer. A one-stage registered AXIS slice keeps the sample rate constant: every beat is forwarded, with raw, zeroed or differentiated data.

Parameters:
AXIS_TDATA_WIDTH, 32, data width of both AXIS ports.
WARMUP_SAMPLES, 7, accepted beats zeroed after enable/restart (5 history taps + 2 pipeline registers); 0 allowed.

Ports:
aclk  in  1  clock
aresetn  in  1  reset; one clock; reset is asynchronous and active-low
enable_req  in  1  level from config register: 1 = differentiate, 0 = bypass
restart  in  1  single-cycle pulse: re-warm after an upstream discontinuity
diff_enable  out  1  drives the differentiator's enable
S_AXIS_tvalid  in  1  beat from the differentiator
S_AXIS_tdata  in  AXIS_TDATA_WIDTH  differentiator output data
S_AXIS_tready  out  1  ready to the differentiator
M_AXIS_tvalid  out  1  beat to the downstream consumer
M_AXIS_tdata  out  AXIS_TDATA_WIDTH  conditioned data
M_AXIS_tready  in  1  downstream ready
state  out  2  status: 0 BYPASS, 1 FILL, 2 RUN
warmup_cnt  out  CNT_W  status: beats counted in FILL, CNT_W = $clog2(WARMUP_SAMPLES+1), min 1

Behaviour:
- Reset (async assert, sync release):
  - state = BYPASS; warmup_cnt = 0; diff_enable = 0.
  - M_AXIS_tvalid = 0; M_AXIS_tdata = 0.
  - S_AXIS_tready = 0 while aresetn = 0.
- Accept = S_AXIS_tvalid & S_AXIS_tready.
  - S_AXIS_tready = ~M_AXIS_tvalid | M_AXIS_tready (single register slice).
- Output register:
  - On accept: M_AXIS_tvalid <= 1 and M_AXIS_tdata <= (state == FILL) ? 0 : S_AXIS_tdata.
  - On M_AXIS_tready with no accept: M_AXIS_tvalid <= 0.
  - Latency is 1 cycle.
  - tdata is held stable while tvalid = 1 and tready = 0.
- Data conditioning uses the state in the accept cycle, before any transition.
- diff_enable = (state != BYPASS), decoded from the state register and glitch-free.
- FSM, evaluated every cycle; priority is top to bottom:
  1. enable_req = 0: any state -> BYPASS; warmup_cnt <= 0.
  2. BYPASS & enable_req = 1 -> FILL, or -> RUN when WARMUP_SAMPLES = 0; warmup_cnt <= 0.
  3. RUN & restart = 1 -> FILL (or stay RUN when WARMUP_SAMPLES = 0); warmup_cnt <= 0.
  4. FILL & restart = 1: stay FILL; warmup_cnt <= 0, even if an accept occurs that cycle.
  5. FILL & accept: if warmup_cnt == WARMUP_SAMPLES-1 -> RUN and warmup_cnt <= 0; else warmup_cnt++.
- restart in BYPASS is ignored.
- Only accepted beats count. Stalled cycles (tvalid = 0 or backpressure) do not advance FILL.
- Exactly WARMUP_SAMPLES zero beats are emitted per warmup, with no gaps or drops. Beat count out equals beat count in.
- Mid-FILL disable returns to BYPASS immediately. The next enable restarts the count from 0.
- Widths: no arithmetic on data. warmup_cnt never exceeds WARMUP_SAMPLES-1.

Decomposition:
- Package axis_differentiator_pkg:
  - typedef enum logic [1:0] diff_state_t {BYPASS = 0, FILL = 1, RUN = 2}.
  - Function cnt_width(n) returning max(1, $clog2(n+1)).
- Sub-module axis_reg_slice:
  - Parameter AXIS_TDATA_WIDTH; async active-low reset.
  - Ports: zero_data, s_tvalid/s_tdata/s_tready, m_tvalid/m_tdata/m_tready.
  - Controller instantiates it and drives zero_data = (state == FILL).
- FSM and counter stay in the top module.

Test Plan:
1. Reset mid-stream with M_AXIS_tvalid = 1 -> M_AXIS_tvalid = 0, tdata = 0, state = 0, diff_enable = 0 within the same cycle (async).
2. BYPASS, continuous valid, tready = 1, data 1, 2, 3 -> M data 1, 2, 3, each one cycle later; diff_enable = 0.
3. enable_req 0 -> 1 with continuous data 10..20 -> diff_enable = 1 next cycle; first 7 output beats after the transition are 0; the 8th beat onward equals input; state goes 1 -> 2 on the 7th accept.
4. FILL with tvalid toggling 1/0 and M_AXIS_tready low for 3 cycles -> still exactly 7 zero beats; no beat lost or duplicated; tdata stable under stall.
5. RUN, restart pulse -> state = 1, next 7 beats 0; restart at warmup_cnt = 4 in FILL -> count resets, 7 further zero beats.
6. enable_req dropped at warmup_cnt = 3 -> BYPASS next cycle, raw data passes, diff_enable = 0. Re-enable with WARMUP_SAMPLES = 0 build -> straight to RUN, no zero beats.
